uart_bus_ctrl: RTL and testbench
================================

# uart_bus_ctrl

Bus-master sequencer that drives the uart_ip local-bus register interface so that hardware requesters can transmit and receive without CPU involvement. It programs CTRL at reset exit and on request. It shares the single UART transmitter between two byte-stream requesters using round-robin arbitration, and drains received bytes to a valid/ready output stream. It sits between on-chip producers/consumers and the uart_ip slave port, in place of the CPU bus connection.

## Interface
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- STRB_W, DATA_W/8, write-strobe width
- BASE_ADDR, 32'h0, uart_ip base address
- START_TO, 16, max STAT polls waiting for tbusy=1 after a start pulse
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cfg_br  in  4  baud select written to CTRL.br
- cfg_clk  in  8  clock divider written to CTRL.clk
- cfg_update  in  1  one-cycle pulse; requests a CTRL rewrite
- tx0_data / tx1_data  in  8  requester bytes
- tx0_valid / tx1_valid  in  1  byte offered
- tx0_ready / tx1_ready  out  1  one-cycle accept pulse
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data valid; held until accepted
- rx_ready  in  1  consumer accept
- err_start  out  1  one-cycle pulse on start timeout
- busy  out  1  high in any state except IDLE_POLL
- m_waddr  out  ADDR_W  write address
- m_wdata  out  DATA_W  write data
- m_wen  out  1  write request
- m_wstrb  out  STRB_W  always all-ones while m_wen=1, else 0
- m_wready  in  1  write complete
- m_raddr  out  ADDR_W  read address
- m_ren  out  1  read request
- m_rdata  in  DATA_W  read data
- m_rvalid  in  1  read data valid

## Operation
- Register offsets: CTRL 0x0, STAT 0x4, TXDATA 0x8, RXDATA 0xC.
- CTRL fields: en[0], strtx[1], br[5:2], clk[15:8].
- STAT fields: tbusy[0], rxne[1].
- TXDATA and RXDATA fields: data[7:0].
- Bus write: assert m_wen with stable m_waddr/m_wdata until the cycle m_wready=1; the transaction completes in that cycle.
- Bus read: assert m_ren with stable m_raddr until m_rvalid=1; m_rdata is sampled in that cycle.
- m_wen and m_ren are never high together.
- FSM states and transitions:
  - INIT_CTRL: write CTRL {en=1, strtx=0, br=cfg_br, clk=cfg_clk}. Then go to IDLE_POLL.
  - IDLE_POLL: read STAT. On completion, choose the next state by priority:
    1. rxne=1 and rx_valid=0 → RD_RX.
    2. cfg_pend=1 → INIT_CTRL; clear cfg_pend.
    3. Any txN_valid → WR_TX. Grant the round-robin winner: pulse its ready and latch its byte.
    4. Otherwise → IDLE_POLL.
  - RD_RX: read RXDATA; load rx_data and set rx_valid. Go to IDLE_POLL. uart_ip clears rxne on an RXDATA read.
  - WR_TX: write TXDATA with the latched byte. Go to WR_START.
  - WR_START: write CTRL with strtx=1 and current en/br/clk. Go to WR_STOP.
  - WR_STOP: write CTRL with strtx=0. Clear the poll counter. Go to WAIT_HI.
  - WAIT_HI: read STAT.
    - tbusy=1 → WAIT_LO.
    - Else increment the counter; when the count reaches START_TO, pulse err_start and go to IDLE_POLL.
  - WAIT_LO: read STAT until tbusy=0, then go to IDLE_POLL.
- cfg_update sets cfg_pend in any state. A pulse arriving in the same cycle cfg_pend is cleared keeps cfg_pend set.
- br/clk are sampled at the moment of each CTRL write.
- Round-robin arbitration:
  - Pointer resets to requester 0.
  - If only one requester is valid, it wins.
  - If both are valid, the pointer's requester wins, and the pointer then moves to the other requester.
  - A requester must hold txN_valid and txN_data stable until it sees its ready pulse.
- rx_valid clears on rx_valid & rx_ready. No new RXDATA read is issued while rx_valid=1; the byte stays buffered in uart_ip.

## Timing
- Reset values:
  - All outputs 0, except m_waddr/m_raddr = BASE_ADDR, and busy = 1.
  - FSM enters INIT_CTRL.
  - cfg_pend 0, RR pointer 0.
- The first m_wen rises in the first clk edge after rst deasserts.
- txN_ready pulses in the same cycle as the STAT read completion that grants it. m_wen for TXDATA is asserted from the next cycle.
- rx_valid rises the cycle after RD_RX completes.
- Minimum bus-cycle count per transmitted byte with zero-wait slave: 1 STAT + 3 writes + ≥2 STAT.
- Reset asserted mid-operation aborts any bus transaction immediately: m_wen and m_ren drop asynchronously, rx_data is discarded, and a latched TX byte is lost.

## Structure
- Package uart_bus_pkg contains:
  - offset constants, CTRL/STAT bit positions, the state enum;
  - a function building the CTRL word from en/strtx/br/clk.
- Sub-module uart_bus_rr_arb holds the 2-way round-robin arbiter: inputs valid[1:0] and advance; outputs one-hot grant.
- All other logic lives in uart_bus_ctrl.

## Test plan
- Reset with cfg_br=4'h3, cfg_clk=8'h1B → first write is CTRL at addr BASE+0x0 with data 0x0000_1B0D, m_wstrb=4'hF.
- tx0 offers 0x41; the model slave STAT returns tbusy 0,1,1,0 → writes in order TXDATA=0x41, CTRL strtx=1, CTRL strtx=0; tx0_ready pulses exactly once.
- tx0 and tx1 both continuously valid for 4 bytes → grants alternate 0,1,0,1.
- Slave STAT rxne=1 with RXDATA=0x5A, rx_ready=0 → rx_data=0x5A held; no further RXDATA read until rx_ready=1.
- After a start, tbusy stays 0 → err_start pulses after exactly START_TO WAIT_HI polls; the FSM returns to IDLE_POLL.
- Assert rst while m_wen=1 with slave wready=0 → m_wen=0 immediately; after release, INIT_CTRL is reissued.

Source files
------------

// File: rtl/uart_bus_pkg.sv
// Shared constants, state encoding and CTRL word builder for the
// uart_ip bus-master sequencer.
package uart_bus_pkg;

   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_STAT   = 8'h04;
   localparam logic [7:0] OFF_TXDATA = 8'h08;
   localparam logic [7:0] OFF_RXDATA = 8'h0C;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_STRTX = 1;
   localparam int CTRL_BR    = 2;
   localparam int CTRL_CLK   = 8;

   localparam int STAT_TBUSY = 0;
   localparam int STAT_RXNE  = 1;

   typedef enum logic [2:0] {
      INIT_CTRL,
      IDLE_POLL,
      RD_RX,
      WR_TX,
      WR_START,
      WR_STOP,
      WAIT_HI,
      WAIT_LO
   } state_e;

   function automatic logic [31:0] ctrl_word(
      input logic       en,
      input logic       strtx,
      input logic [3:0] br,
      input logic [7:0] clkdiv
   );
      logic [31:0] w;
      w                 = '0;
      w[CTRL_EN]        = en;
      w[CTRL_STRTX]     = strtx;
      w[CTRL_BR +: 4]   = br;
      w[CTRL_CLK +: 8]  = clkdiv;
      return w;
   endfunction

endpackage

// File: rtl/uart_bus_rr_arb.sv
// Two-way round-robin arbiter; the pointer only moves when both
// requesters competed for a grant that was taken.
module uart_bus_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      grant = valid;
      ptr_d = ptr_q;
      if (&valid) begin
         grant = ptr_q ? 2'b10 : 2'b01;
         if (advance) begin
            ptr_d = ~ptr_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/uart_bus_ctrl.sv
// Bus-master sequencer for uart_ip: programs CTRL, arbitrates two TX
// byte streams onto the transmitter and drains RX to a stream.
module uart_bus_ctrl
   import uart_bus_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                STRB_W    = DATA_W / 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                START_TO  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        cfg_br,
   input  logic [7:0]        cfg_clk,
   input  logic              cfg_update,
   input  logic [7:0]        tx0_data,
   input  logic              tx0_valid,
   output logic              tx0_ready,
   input  logic [7:0]        tx1_data,
   input  logic              tx1_valid,
   output logic              tx1_ready,
   output logic [7:0]        rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              err_start,
   output logic              busy,
   output logic [ADDR_W-1:0] m_waddr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_wen,
   output logic [STRB_W-1:0] m_wstrb,
   input  logic              m_wready,
   output logic [ADDR_W-1:0] m_raddr,
   output logic              m_ren,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_rvalid
);

   localparam int CNT_W = $clog2(START_TO + 1);

   localparam logic [ADDR_W-1:0] A_CTRL = BASE_ADDR + ADDR_W'(OFF_CTRL);
   localparam logic [ADDR_W-1:0] A_STAT = BASE_ADDR + ADDR_W'(OFF_STAT);
   localparam logic [ADDR_W-1:0] A_TX   = BASE_ADDR + ADDR_W'(OFF_TXDATA);
   localparam logic [ADDR_W-1:0] A_RX   = BASE_ADDR + ADDR_W'(OFF_RXDATA);

   state_e            state_q, state_d;
   logic              wen_q, wen_d;
   logic              ren_q, ren_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cfg_pend_q, cfg_pend_d;
   logic              rx_valid_q, rx_valid_d;
   logic [7:0]        rx_data_q, rx_data_d;

   logic             done;
   logic             launch;
   logic             grant_ev;
   logic             pend_clr;
   logic             rx_load;
   logic             err_ev;
   logic             tbusy;
   logic             rxne;
   logic [1:0]       tx_valid;
   logic [1:0]       grant;
   logic [7:0]       tx_byte;
   logic [CNT_W-1:0] cnt_nxt;
   logic             unused_rdata;

   assign done     = (wen_q & m_wready) | (ren_q & m_rvalid);
   assign tbusy    = m_rdata[STAT_TBUSY];
   assign rxne     = m_rdata[STAT_RXNE];
   assign tx_valid = {tx1_valid, tx0_valid};
   assign tx_byte  = grant[1] ? tx1_data : tx0_data;
   assign cnt_nxt  = cnt_q + 1'b1;

   assign unused_rdata = ^m_rdata[DATA_W-1:8];

   uart_bus_rr_arb u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid   (tx_valid),
      .advance (grant_ev),
      .grant   (grant)
   );

   // Each completion launches the next state's transfer in the same
   // cycle; the idle path only fires once after reset.
   always_comb begin
      state_d  = state_q;
      wen_d    = wen_q;
      ren_d    = ren_q;
      waddr_d  = waddr_q;
      raddr_d  = raddr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      launch   = 1'b0;
      grant_ev = 1'b0;
      pend_clr = 1'b0;
      rx_load  = 1'b0;
      err_ev   = 1'b0;
      if (done) begin
         wen_d  = 1'b0;
         ren_d  = 1'b0;
         launch = 1'b1;
         unique case (state_q)
            INIT_CTRL: state_d = IDLE_POLL;
            IDLE_POLL: begin
               if (rxne && !rx_valid_q) begin
                  state_d = RD_RX;
               end else if (cfg_pend_q) begin
                  state_d  = INIT_CTRL;
                  pend_clr = 1'b1;
               end else if (|tx_valid) begin
                  state_d  = WR_TX;
                  grant_ev = 1'b1;
               end
            end
            RD_RX: begin
               state_d = IDLE_POLL;
               rx_load = 1'b1;
            end
            WR_TX:    state_d = WR_START;
            WR_START: state_d = WR_STOP;
            WR_STOP: begin
               state_d = WAIT_HI;
               cnt_d   = '0;
            end
            WAIT_HI: begin
               if (tbusy) begin
                  state_d = WAIT_LO;
               end else begin
                  cnt_d = cnt_nxt;
                  if (cnt_nxt == CNT_W'(START_TO)) begin
                     err_ev  = 1'b1;
                     state_d = IDLE_POLL;
                  end
               end
            end
            WAIT_LO: begin
               if (!tbusy) begin
                  state_d = IDLE_POLL;
               end
            end
         endcase
      end else if (!wen_q && !ren_q) begin
         launch = 1'b1;
      end
      if (launch) begin
         unique case (state_d)
            INIT_CTRL, WR_STOP: begin
               wen_d   = 1'b1;
               waddr_d = A_CTRL;
               wdata_d = DATA_W'(ctrl_word(1'b1, 1'b0, cfg_br, cfg_clk));
            end
            WR_START: begin
               wen_d   = 1'b1;
               waddr_d = A_CTRL;
               wdata_d = DATA_W'(ctrl_word(1'b1, 1'b1, cfg_br, cfg_clk));
            end
            WR_TX: begin
               wen_d   = 1'b1;
               waddr_d = A_TX;
               wdata_d = DATA_W'(tx_byte);
            end
            RD_RX: begin
               ren_d   = 1'b1;
               raddr_d = A_RX;
            end
            default: begin
               ren_d   = 1'b1;
               raddr_d = A_STAT;
            end
         endcase
      end
   end

   always_comb begin
      cfg_pend_d = (cfg_pend_q & ~pend_clr) | cfg_update;
      rx_valid_d = rx_valid_q & ~rx_ready;
      rx_data_d  = rx_data_q;
      if (rx_load) begin
         rx_valid_d = 1'b1;
         rx_data_d  = m_rdata[7:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= INIT_CTRL;
         wen_q      <= 1'b0;
         ren_q      <= 1'b0;
         waddr_q    <= BASE_ADDR;
         raddr_q    <= BASE_ADDR;
         wdata_q    <= '0;
         cnt_q      <= '0;
         cfg_pend_q <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wen_q      <= wen_d;
         ren_q      <= ren_d;
         waddr_q    <= waddr_d;
         raddr_q    <= raddr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         cfg_pend_q <= cfg_pend_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

   assign m_wen     = wen_q;
   assign m_ren     = ren_q;
   assign m_waddr   = waddr_q;
   assign m_raddr   = raddr_q;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = {STRB_W{wen_q}};
   assign tx0_ready = grant_ev & grant[0];
   assign tx1_ready = grant_ev & grant[1];
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign err_start = err_ev;
   assign busy      = (state_q != IDLE_POLL);

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Bench for uart_bus_ctrl: scripted uart_ip slave model plus a
// transaction-level expectation of the bus traffic and grants.
`timescale 1ns/1ps
module tb_uart_bus_ctrl;

   localparam int          AW   = 32;
   localparam int          DW   = 32;
   localparam int          TO   = 6;
   localparam logic [31:0] BASE = 32'h4000_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    cfg_br = 4'h3;
   logic [7:0]    cfg_clk = 8'h1B;
   logic          cfg_update = 1'b0;
   logic [7:0]    tx0_data = 8'h0;
   logic          tx0_valid = 1'b0;
   logic          tx0_ready;
   logic [7:0]    tx1_data = 8'h0;
   logic          tx1_valid = 1'b0;
   logic          tx1_ready;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready = 1'b0;
   logic          err_start;
   logic          busy;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   logic          m_wen;
   logic [3:0]    m_wstrb;
   logic          m_wready;
   logic [AW-1:0] m_raddr;
   logic          m_ren;
   logic [DW-1:0] m_rdata;
   logic          m_rvalid;

   always #5 clk = ~clk;

   uart_bus_ctrl #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .STRB_W    (DW / 8),
      .BASE_ADDR (BASE),
      .START_TO  (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_br     (cfg_br),
      .cfg_clk    (cfg_clk),
      .cfg_update (cfg_update),
      .tx0_data   (tx0_data),
      .tx0_valid  (tx0_valid),
      .tx0_ready  (tx0_ready),
      .tx1_data   (tx1_data),
      .tx1_valid  (tx1_valid),
      .tx1_ready  (tx1_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .err_start  (err_start),
      .busy       (busy),
      .m_waddr    (m_waddr),
      .m_wdata    (m_wdata),
      .m_wen      (m_wen),
      .m_wstrb    (m_wstrb),
      .m_wready   (m_wready),
      .m_raddr    (m_raddr),
      .m_ren      (m_ren),
      .m_rdata    (m_rdata),
      .m_rvalid   (m_rvalid)
   );

   // uart_ip slave model: STAT.tbusy follows a script, RX bytes a buffer
   logic        script [0:255];
   int          slen = 0;
   int          sidx = 0;
   logic [7:0]  rxb [0:255];
   int          rx_wr = 0;
   int          rx_rd = 0;
   logic        stall_w = 1'b0;
   logic [31:0] off;
   logic        stat_tb;
   logic        rxne;

   assign off      = m_raddr - BASE;
   assign stat_tb  = (sidx < slen) ? script[sidx[7:0]] : 1'b0;
   assign rxne     = (rx_rd != rx_wr);
   assign m_rdata  = (off == 32'hC) ? {24'h0, rxb[rx_rd[7:0]]}
                                    : {30'h0, rxne, stat_tb};
   assign m_rvalid = m_ren;
   assign m_wready = m_wen & ~stall_w;

   always @(posedge clk) begin
      if (m_ren && m_rvalid) begin
         if (off == 32'h4 && sidx < slen) sidx <= sidx + 1;
         if (off == 32'hC && rx_rd != rx_wr) rx_rd <= rx_rd + 1;
      end
   end

   // transaction monitor
   logic [31:0] wq_addr [$];
   logic [31:0] wq_data [$];
   int          gq [$];
   int          nstat = 0;
   int          nrx = 0;
   int          n_err = 0;
   int          since_stop = 0;
   int          err_at = -1;

   always @(negedge clk) begin
      if (!rst) begin
         if (m_wen && m_wready) begin
            wq_addr.push_back(m_waddr);
            wq_data.push_back(m_wdata);
            if (m_waddr == BASE && !m_wdata[1]) since_stop = 0;
         end
         if (m_ren && m_rvalid) begin
            if (off == 32'h4) begin
               nstat++;
               since_stop++;
            end else if (off == 32'hC) begin
               nrx++;
            end
         end
         if (err_start) begin
            n_err++;
            err_at = since_stop;
         end
         if (tx0_ready) gq.push_back(0);
         if (tx1_ready) gq.push_back(1);
      end
   end

   int n_cmp = 0;
   int n_fail = 0;
   int model_ptr = 0;

   function automatic logic [31:0] exp_ctrl(input logic st);
      return {16'h0, cfg_clk, 2'b00, cfg_br, st, 1'b1};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_busy(input logic lvl, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (busy === lvl) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic wait_grants(input int n, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (gq.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic clear_logs();
      wq_addr.delete();
      wq_data.delete();
      gq.delete();
   endtask

   task automatic test_reset();
      logic ok;
      rst = 1'b1;
      cfg_br = 4'h3;
      cfg_clk = 8'h1B;
      repeat (3) step();
      n_cmp++;
      if (m_wen !== 1'b0 || m_ren !== 1'b0 || m_wstrb !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_bus wen=%b ren=%b strb=%h want 0 0 0",
                  m_wen, m_ren, m_wstrb);
      end
      n_cmp++;
      if (m_waddr !== BASE || m_raddr !== BASE) begin
         n_fail++;
         $display("FAIL reset_addr waddr=%h raddr=%h want %h",
                  m_waddr, m_raddr, BASE);
      end
      n_cmp++;
      if (busy !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h0 ||
          err_start !== 1'b0 || tx0_ready !== 1'b0 ||
          tx1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out busy=%b rxv=%b rxd=%h err=%b rdy=%b%b",
                  busy, rx_valid, rx_data, err_start, tx1_ready, tx0_ready);
      end
      model_ptr = 0;
      rst = 1'b0;
      step();
      n_cmp++;
      if (m_wen !== 1'b1 || m_waddr !== BASE || m_wdata !== 32'h0000_1B0D ||
          m_wstrb !== 4'hF) begin
         n_fail++;
         $display("FAIL first_write wen=%b addr=%h data=%h strb=%h want 1 %h 00001b0d f",
                  m_wen, m_waddr, m_wdata, m_wstrb, BASE);
      end
      wait_busy(1'b0, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL reset_idle busy=%b want 0", busy);
      end
   endtask

   task automatic test_single_tx();
      logic       ok;
      logic [7:0] b;
      int         s0;
      clear_logs();
      b = 8'($urandom);
      tx0_data = b;
      tx0_valid = 1'b1;
      script[slen[7:0]] = 1'b0; slen++;
      script[slen[7:0]] = 1'b1; slen++;
      script[slen[7:0]] = 1'b1; slen++;
      script[slen[7:0]] = 1'b0; slen++;
      wait_grants(1, ok);
      tx0_valid = 1'b0;
      s0 = nstat;
      if (ok) wait_busy(1'b0, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_tx_timeout grants=%0d busy=%b", gq.size(), busy);
      end
      n_cmp++;
      if (gq.size() != 1 || gq[0] != 0) begin
         n_fail++;
         $display("FAIL single_ready pulses=%0d want 1 on tx0", gq.size());
      end
      n_cmp++;
      if (wq_addr.size() != 3) begin
         n_fail++;
         $display("FAIL single_nwrites got %0d want 3", wq_addr.size());
      end else begin
         n_cmp++;
         if (wq_addr[0] !== BASE + 32'h8 || wq_data[0] !== {24'h0, b}) begin
            n_fail++;
            $display("FAIL single_txdata %h=%h want %h=%h",
                     wq_addr[0], wq_data[0], BASE + 32'h8, b);
         end
         n_cmp++;
         if (wq_addr[1] !== BASE || wq_data[1] !== exp_ctrl(1'b1)) begin
            n_fail++;
            $display("FAIL single_start %h=%h want %h=%h",
                     wq_addr[1], wq_data[1], BASE, exp_ctrl(1'b1));
         end
         n_cmp++;
         if (wq_addr[2] !== BASE || wq_data[2] !== exp_ctrl(1'b0)) begin
            n_fail++;
            $display("FAIL single_stop %h=%h want %h=%h",
                     wq_addr[2], wq_data[2], BASE, exp_ctrl(1'b0));
         end
      end
      n_cmp++;
      if (nstat - s0 != 3) begin
         n_fail++;
         $display("FAIL single_polls got %0d want 3", nstat - s0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d0, d1;
      logic [7:0] exp_b [$];
      int         ng, w;
      logic       ok;
      clear_logs();
      cfg_br = 4'($urandom);
      cfg_clk = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
         script[slen[7:0]] = 1'b0; slen++;
         script[slen[7:0]] = 1'b1; slen++;
         script[slen[7:0]] = 1'b0; slen++;
      end
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      tx0_data = d0;
      tx1_data = d1;
      tx0_valid = 1'b1;
      tx1_valid = 1'b1;
      ng = 0;
      for (int c = 0; c < 400 && ng < 4; c++) begin
         step();
         if (gq.size() > ng) begin
            w = model_ptr;
            model_ptr = 1 - model_ptr;
            exp_b.push_back(w == 1 ? d1 : d0);
            n_cmp++;
            if (gq[ng] != w) begin
               n_fail++;
               $display("FAIL rr_grant%0d got tx%0d want tx%0d", ng, gq[ng], w);
            end
            if (gq[ng] == 0) begin
               d0 = 8'($urandom);
               tx0_data = d0;
            end else begin
               d1 = 8'($urandom);
               tx1_data = d1;
            end
            ng++;
         end
      end
      tx0_valid = 1'b0;
      tx1_valid = 1'b0;
      wait_busy(1'b0, ok);
      n_cmp++;
      if (ng != 4 || !ok || gq.size() != 4) begin
         n_fail++;
         $display("FAIL rr_count grants=%0d want 4 idle=%b", gq.size(), ok);
      end
      n_cmp++;
      if (wq_addr.size() != 12) begin
         n_fail++;
         $display("FAIL rr_nwrites got %0d want 12", wq_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (wq_addr[3*i] !== BASE + 32'h8 ||
                wq_data[3*i] !== {24'h0, exp_b[i]} ||
                wq_data[3*i+1] !== exp_ctrl(1'b1) ||
                wq_data[3*i+2] !== exp_ctrl(1'b0)) begin
               n_fail++;
               $display("FAIL rr_byte%0d tx=%h start=%h stop=%h want %h %h %h",
                        i, wq_data[3*i], wq_data[3*i+1], wq_data[3*i+2],
                        exp_b[i], exp_ctrl(1'b1), exp_ctrl(1'b0));
            end
         end
      end
   endtask

   task automatic test_cfg_update();
      logic ok;
      clear_logs();
      cfg_br = 4'($urandom);
      cfg_clk = 8'($urandom);
      cfg_update = 1'b1;
      step();
      cfg_update = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (wq_addr.size() > 0) begin
            ok = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!ok || wq_addr[0] !== BASE || wq_data[0] !== exp_ctrl(1'b0)) begin
         n_fail++;
         $display("FAIL cfg_rewrite seen=%b %h=%h want %h=%h",
                  ok, wq_addr[0], wq_data[0], BASE, exp_ctrl(1'b0));
      end
      wait_busy(1'b0, ok);
   endtask

   task automatic test_rx();
      logic [7:0] b1, b2;
      logic       ok;
      int         n0;
      clear_logs();
      n0 = nrx;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      rxb[rx_wr[7:0]] = b1; rx_wr++;
      rxb[rx_wr[7:0]] = b2; rx_wr++;
      rx_ready = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (rx_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!ok || rx_data !== b1) begin
         n_fail++;
         $display("FAIL rx_first valid=%b data=%h want 1 %h", ok, rx_data, b1);
      end
      repeat (20) step();
      n_cmp++;
      if (nrx - n0 != 1 || rx_valid !== 1'b1 || rx_data !== b1) begin
         n_fail++;
         $display("FAIL rx_hold reads=%0d valid=%b data=%h want 1 1 %h",
                  nrx - n0, rx_valid, rx_data, b1);
      end
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      n_cmp++;
      if (rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rx_accept valid=%b want 0", rx_valid);
      end
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (rx_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!ok || rx_data !== b2 || nrx - n0 != 2) begin
         n_fail++;
         $display("FAIL rx_second valid=%b data=%h reads=%0d want 1 %h 2",
                  ok, rx_data, nrx - n0, b2);
      end
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
   endtask

   task automatic test_start_timeout();
      logic ok;
      clear_logs();
      tx1_data = 8'($urandom);
      tx1_valid = 1'b1;
      script[slen[7:0]] = 1'b0; slen++;
      wait_grants(1, ok);
      tx1_valid = 1'b0;
      n_cmp++;
      if (!ok || gq[0] != 1) begin
         n_fail++;
         $display("FAIL to_grant seen=%b got tx%0d want tx1", ok, gq[0]);
      end
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (n_err > 0) begin
            ok = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!ok || err_at != TO) begin
         n_fail++;
         $display("FAIL to_polls seen=%b polls=%0d want %0d", ok, err_at, TO);
      end
      repeat (5) step();
      n_cmp++;
      if (n_err != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL to_return errs=%0d busy=%b want 1 0", n_err, busy);
      end
   endtask

   task automatic test_reset_mid();
      logic ok;
      clear_logs();
      stall_w = 1'b1;
      cfg_br = 4'($urandom);
      cfg_clk = 8'($urandom);
      cfg_update = 1'b1;
      step();
      cfg_update = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (m_wen === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      step();
      n_cmp++;
      if (!ok || m_wen !== 1'b1 || m_waddr !== BASE) begin
         n_fail++;
         $display("FAIL mid_stalled seen=%b wen=%b addr=%h", ok, m_wen, m_waddr);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (m_wen !== 1'b0 || m_ren !== 1'b0 || busy !== 1'b1 ||
          m_wstrb !== 4'h0) begin
         n_fail++;
         $display("FAIL mid_abort wen=%b ren=%b busy=%b strb=%h want 0 0 1 0",
                  m_wen, m_ren, busy, m_wstrb);
      end
      stall_w = 1'b0;
      step();
      step();
      model_ptr = 0;
      rst = 1'b0;
      step();
      n_cmp++;
      if (m_wen !== 1'b1 || m_waddr !== BASE || m_wdata !== exp_ctrl(1'b0) ||
          rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reinit wen=%b %h=%h rxv=%b want 1 %h=%h 0",
                  m_wen, m_waddr, m_wdata, rx_valid, BASE, exp_ctrl(1'b0));
      end
      wait_busy(1'b0, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL mid_idle busy=%b want 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_single_tx();
      test_back_to_back();
      test_cfg_update();
      test_rx();
      test_start_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
